// File: rtl/fifo_serial_tx.sv
// Serial transmitter draining 4-bit words from a small FIFO's read port.
// Frame: start bit, WIDTH data bits LSB first, optional even parity, stop bit.
module fifo_serial_tx #(
  parameter int WIDTH  = 4,
  parameter int DIV    = 4,
  parameter int PARITY = 0
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             empty,
  input  logic [WIDTH-1:0] rdata,
  output logic             ren,
  output logic             tx,
  output logic             busy
);

  localparam int CW = $clog2(DIV);
  localparam int IW = $clog2(WIDTH) + 1;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] PAR   = 3'd3;
  localparam logic [2:0] STOP  = 3'd4;

  logic [2:0]       state;
  logic [CW-1:0]    cnt;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] sh_next;
  logic             par;
  logic             bit_end;

  assign bit_end = (cnt == CW'(DIV - 1));
  assign sh_next = sh >> 1;
  assign busy    = (state != IDLE);
  // Gating with RESETN keeps the pop strobe low while reset is held.
  assign ren     = RESETN & (state == IDLE) & ~empty;

  // tx is registered: each transition loads the level of the bit being entered.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state <= IDLE;
      tx    <= 1'b1;
      cnt   <= '0;
      idx   <= '0;
      sh    <= '0;
      par   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            sh    <= rdata;
            par   <= ^rdata;
            cnt   <= '0;
            idx   <= '0;
            tx    <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (bit_end) begin
            cnt   <= '0;
            tx    <= sh[0];
            state <= DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt <= '0;
            sh  <= sh_next;
            if (idx == IW'(WIDTH - 1)) begin
              idx   <= '0;
              state <= (PARITY != 0) ? PAR : STOP;
              tx    <= (PARITY != 0) ? par : 1'b1;
            end else begin
              idx <= idx + IW'(1);
              tx  <= sh_next[0];
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        PAR: begin
          if (bit_end) begin
            cnt   <= '0;
            tx    <= 1'b1;
            state <= STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Bench for fifo_serial_tx: four parameterisations share one queue-based FIFO model;
// only the selected instance sees a non-empty FIFO.
module tb_fifo_serial_tx;

  logic       CLK = 1'b0;
  logic       RESETN = 1'b0;
  logic [2:0] sel = 3'd4;
  logic       push_req = 1'b0;
  logic [3:0] push_data = '0;
  logic       fifo_empty = 1'b1;
  logic [3:0] fifo_head = '0;
  logic [3:0] empty_v, ren_v, tx_v, busy_v;
  logic       ren_sel, tx_sel;

  int unsigned ncomp = 0;
  int unsigned nfail = 0;
  int unsigned bad_pops = 0;

  logic [3:0] fq[$];
  logic [3:0] plan[$];
  logic [3:0] sent[$];
  logic [3:0] dq_word[$];
  bit         dq_ok[$];

  always #5 CLK = ~CLK;

  always_comb begin
    for (int i = 0; i < 4; i++) empty_v[i] = !((sel == 3'(i)) && !fifo_empty);
    ren_sel = (sel < 3'd4) ? ren_v[sel[1:0]] : 1'b0;
    tx_sel  = (sel < 3'd4) ? tx_v[sel[1:0]]  : 1'b1;
  end

  fifo_serial_tx #(.WIDTH(4), .DIV(4), .PARITY(0)) u0 (
    .CLK(CLK), .RESETN(RESETN), .empty(empty_v[0]), .rdata(fifo_head),
    .ren(ren_v[0]), .tx(tx_v[0]), .busy(busy_v[0]));
  fifo_serial_tx #(.WIDTH(4), .DIV(4), .PARITY(1)) u1 (
    .CLK(CLK), .RESETN(RESETN), .empty(empty_v[1]), .rdata(fifo_head),
    .ren(ren_v[1]), .tx(tx_v[1]), .busy(busy_v[1]));
  fifo_serial_tx #(.WIDTH(4), .DIV(2), .PARITY(0)) u2 (
    .CLK(CLK), .RESETN(RESETN), .empty(empty_v[2]), .rdata(fifo_head),
    .ren(ren_v[2]), .tx(tx_v[2]), .busy(busy_v[2]));
  fifo_serial_tx #(.WIDTH(4), .DIV(3), .PARITY(1)) u3 (
    .CLK(CLK), .RESETN(RESETN), .empty(empty_v[3]), .rdata(fifo_head),
    .ren(ren_v[3]), .tx(tx_v[3]), .busy(busy_v[3]));

  // FIFO model: pop then push on the edge, flags published as registered values.
  always @(posedge CLK) begin
    if (ren_sel && fq.size() > 0) void'(fq.pop_front());
    if (push_req) fq.push_back(push_data);
    fifo_empty <= (fq.size() == 0);
    fifo_head  <= (fq.size() != 0) ? fq[0] : 4'h0;
  end

  always @(negedge CLK)
    for (int i = 0; i < 4; i++) if (ren_v[i] && empty_v[i]) bad_pops++;

  // UART receiver model: samples each bit at its centre on the selected line.
  bit          rx_on = 1'b0;
  int unsigned rx_t = 0;
  logic [7:0]  rx_bits = '0;
  always @(negedge CLK) begin
    int unsigned div, nb, k;
    bit par;
    div = (sel[1:0] == 2'd2) ? 2 : (sel[1:0] == 2'd3) ? 3 : 4;
    par = sel[0];
    nb  = 6 + int'(par);
    if (!RESETN || sel > 3'd3) rx_on = 1'b0;
    else if (!rx_on) begin
      if (tx_sel == 1'b0) begin rx_on = 1'b1; rx_t = 0; end
    end else rx_t++;
    if (rx_on && (rx_t % div) == div / 2) begin
      k = rx_t / div;
      rx_bits[k] = tx_sel;
      if (k == nb - 1) begin
        dq_word.push_back(rx_bits[4:1]);
        dq_ok.push_back(!rx_bits[0] && rx_bits[nb-1] && (!par || rx_bits[5] == ^rx_bits[4:1]));
        rx_on = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [3:0] w);
    push_req = 1'b1;
    push_data = w;
    @(negedge CLK);
    push_req = 1'b0;
  endtask

  task automatic preload(input logic [3:0] w);
    push_word(w);
    plan.push_back(w);
  endtask

  function automatic logic frame_bit(input logic [3:0] w, input int unsigned k, input int unsigned par);
    if (k == 0) return 1'b0;
    if (k <= 4) return w[k-1];
    if (k == 5 && par != 0) return ^w;
    return 1'b1;
  endfunction

  // Expected line per cycle: pop cycle, then (6+par)*div bit cycles, per planned word.
  task automatic run_check(input logic [1:0] inst, input int unsigned div, input int unsigned par);
    int unsigned n, period, total, f, r;
    logic etx, ebusy, eren;
    n = plan.size();
    period = (6 + par) * div + 1;
    total = n * period + 2;
    sel = {1'b0, inst};
    for (int unsigned c = 0; c < total; c++) begin
      if (c != 0) @(negedge CLK);
      #1;
      f = c / period;
      r = c % period;
      if (f < n && r == 0) {eren, etx, ebusy} = 3'b110;
      else if (f < n) begin
        eren = 1'b0; ebusy = 1'b1;
        etx = frame_bit(plan[f], (r - 1) / div, par);
      end else {eren, etx, ebusy} = 3'b010;
      chk($sformatf("ren%0d_c%0d", inst, c), {7'd0, ren_v[inst]}, {7'd0, eren});
      chk($sformatf("tx%0d_c%0d", inst, c), {7'd0, tx_v[inst]}, {7'd0, etx});
      chk($sformatf("busy%0d_c%0d", inst, c), {7'd0, busy_v[inst]}, {7'd0, ebusy});
    end
    @(negedge CLK);
    sel = 3'd4;
    plan.delete();
  endtask

  initial begin
    logic [3:0] w;
    int unsigned waited;
    logic [3:0] exp_b2b[3];

    // Reset holds outputs quiet even with a word waiting.
    repeat (2) @(negedge CLK);
    preload(4'hA);
    sel = 3'd0;
    @(negedge CLK); #1;
    chk("rst_ren", {7'd0, ren_v[0]}, 8'd0);
    chk("rst_tx", {7'd0, tx_v[0]}, 8'd1);
    chk("rst_busy", {7'd0, busy_v[0]}, 8'd0);
    @(negedge CLK);
    sel = 3'd4;
    RESETN = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK); #1;
      chk($sformatf("idle_ren_%0d", i), {7'd0, ren_v[0]}, 8'd0);
      chk($sformatf("idle_tx_%0d", i), {7'd0, tx_v[0]}, 8'd1);
    end
    @(negedge CLK);

    // Single frame, word A, DIV=4.
    run_check(2'd0, 4, 0);

    // Parity frames: 7 -> parity 1, 3 -> parity 0.
    preload(4'h7);
    preload(4'h3);
    run_check(2'd1, 4, 1);

    // Back-to-back, DIV=2.
    exp_b2b = '{4'h1, 4'hF, 4'h0};
    dq_word.delete(); dq_ok.delete();
    for (int i = 0; i < 3; i++) preload(exp_b2b[i]);
    run_check(2'd2, 2, 0);
    chk("b2b_count", 8'(dq_word.size()), 8'd3);
    for (int i = 0; i < 3 && i < dq_word.size(); i++) begin
      chk($sformatf("b2b_word_%0d", i), {4'd0, dq_word[i]}, {4'd0, exp_b2b[i]});
      chk($sformatf("b2b_ok_%0d", i), {7'd0, dq_ok[i]}, 8'd1);
    end
    chk("b2b_empty", {7'd0, fifo_empty}, 8'd1);

    // Reset during data bit 2 (cycles 13-16 of the frame).
    dq_word.delete(); dq_ok.delete();
    preload(4'h9);
    preload(4'h6);
    sel = 3'd0;
    repeat (14) @(negedge CLK);
    #1 RESETN = 1'b0;
    #1;
    chk("mid_tx", {7'd0, tx_v[0]}, 8'd1);
    chk("mid_busy", {7'd0, busy_v[0]}, 8'd0);
    chk("mid_ren", {7'd0, ren_v[0]}, 8'd0);
    repeat (2) @(negedge CLK);
    RESETN = 1'b1;
    void'(plan.pop_front());
    run_check(2'd0, 4, 0);
    chk("mid_count", 8'(dq_word.size()), 8'd1);
    if (dq_word.size() > 0) chk("mid_word", {4'd0, dq_word[0]}, 8'h06);

    // Random traffic through the FIFO, DIV=3 with parity.
    dq_word.delete(); dq_ok.delete();
    sel = 3'd3;
    for (int i = 0; i < 200; i++) begin
      w = 4'($urandom);
      push_word(w);
      sent.push_back(w);
      repeat ($urandom_range(0, 30)) @(negedge CLK);
    end
    waited = 0;
    while (!(fifo_empty && !busy_v[3] && !rx_on) && waited < 10000) begin
      @(negedge CLK);
      waited++;
    end
    chk("sb_drain", {7'd0, waited < 10000}, 8'd1);
    chk("sb_count", 8'(dq_word.size()), 8'(sent.size()));
    for (int i = 0; i < sent.size() && i < dq_word.size(); i++) begin
      chk($sformatf("sb_word_%0d", i), {4'd0, dq_word[i]}, {4'd0, sent[i]});
      chk($sformatf("sb_ok_%0d", i), {7'd0, dq_ok[i]}, 8'd1);
    end
    chk("bad_pops", 8'(bad_pops), 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
